// File: rtl/stream_stb_pkg.sv
// Shared types and helpers for the valid/ready to stb/ack bridge.
//   state_e     : output FSM states (idle, presenting a word, one-cycle gap)
//   level_width : bit width needed to hold an occupancy of 0..depth
package stream_stb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StPresent,
      StGap
   } state_e;

   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO holding {last, data} words for the bridge.
//   clk, rst  : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata: write wdata at tail (caller guarantees not full)
//   pop       : drop head (caller guarantees not empty)
//   rdata     : current head word
//   level     : registered occupancy 0..DEPTH
//   empty     : level == 0
module stream_fifo
   import stream_stb_pkg::*;
#(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned LvlW = level_width(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic [WIDTH-1:0] wdata,
   input  logic            pop,
   output logic [WIDTH-1:0] rdata,
   output logic [LvlW-1:0] level,
   output logic            empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]  level_q, level_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         // DEPTH is a power of two, so pointers wrap by natural overflow
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
         2'b10:   level_d = level_q + LvlW'(1);
         2'b01:   level_d = level_q - LvlW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign level = level_q;
   assign empty = (level_q == '0);

endmodule

// File: rtl/stream_stb_bridge.sv
// Bridge from a valid/ready word stream to a chip stb/ack input port.
// Words are buffered in a small FIFO; each is presented with out_stb held and
// data stable until out_ack, followed by one cycle with out_stb low.
//   clk, rst          : clock, asynchronous active-low reset
//   in_data/last/valid: upstream word, accepted when in_valid && in_ready
//   in_ready          : FIFO not full (from registered level only)
//   out_data/last/stb : word presented to the chip
//   out_ack           : chip acknowledge, honoured only while presenting
//   level             : FIFO occupancy
//   words_sent        : completed stb/ack transfers, wraps at 2^32
module stream_stb_bridge
   import stream_stb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH_BYTES = 4,
   parameter int unsigned DEPTH            = 4,
   localparam int unsigned W    = 8 * DATA_WIDTH_BYTES,
   localparam int unsigned LvlW = level_width(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [W-1:0]    in_data,
   input  logic            in_valid,
   input  logic            in_last,
   output logic            in_ready,
   output logic [W-1:0]    out_data,
   output logic            out_last,
   output logic            out_stb,
   input  logic            out_ack,
   output logic [LvlW-1:0] level,
   output logic [31:0]     words_sent
);

   state_e        state_q, state_d;
   logic          out_stb_q, out_stb_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic          out_last_q, out_last_d;
   logic [31:0]   words_sent_q, words_sent_d;
   logic          push, pop, fifo_empty;
   logic [W:0]    head;

   // A slot freed by a pop only becomes visible through level next cycle.
   assign in_ready = rst && (level != LvlW'(DEPTH));
   assign push     = in_valid && in_ready;

   stream_fifo #(
      .WIDTH (W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({in_last, in_data}),
      .pop   (pop),
      .rdata (head),
      .level (level),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      out_stb_d    = out_stb_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      words_sent_d = words_sent_q;
      pop          = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               state_d                  = StPresent;
               out_stb_d                = 1'b1;
               {out_last_d, out_data_d} = head;
            end
         end
         StPresent: begin
            if (out_ack) begin
               pop          = 1'b1;
               words_sent_d = words_sent_q + 32'd1;
               state_d      = StGap;
               out_stb_d    = 1'b0;
            end
         end
         StGap: begin
            // Ack is ignored here: the chip's registered ack may still be high.
            if (!fifo_empty) begin
               state_d                  = StPresent;
               out_stb_d                = 1'b1;
               {out_last_d, out_data_d} = head;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         out_stb_q    <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         words_sent_q <= '0;
      end else begin
         state_q      <= state_d;
         out_stb_q    <= out_stb_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         words_sent_q <= words_sent_d;
      end
   end

   assign out_stb    = out_stb_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign words_sent = words_sent_q;

endmodule

// File: tb/tb_stream_stb_bridge.sv
module tb_stream_stb_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_stb;
   logic        out_ack = 1'b0;
   logic [2:0]  level;
   logic [31:0] words_sent;

   always #5 clk = ~clk;

   stream_stb_bridge #(
      .DATA_WIDTH_BYTES (4),
      .DEPTH            (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_stb    (out_stb),
      .out_ack    (out_ack),
      .level      (level),
      .words_sent (words_sent)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: words accepted upstream queue here, popped on each stb/ack handshake.
   // Sampled 2 time units after the falling edge, i.e. well before the rising edge.
   logic [32:0] sb_q[$];
   logic [32:0] sb_e;

   always begin
      @(negedge clk);
      #2;
      if (rst) begin
         if (out_stb && out_ack) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: got word 0x%0h, expected none", out_data);
            end else begin
               sb_e = sb_q.pop_front();
               chk("sb_data", out_data, sb_e[31:0]);
               chk("sb_last", 32'(out_last), 32'(sb_e[32]));
            end
         end
         if (in_valid && in_ready) sb_q.push_back({in_last, in_data});
      end
   end

   task automatic wait_ws(input string name, input logic [31:0] target, input int budget);
      int c = 0;
      while (words_sent !== target && c < budget) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk(name, words_sent, target);
   endtask

   typedef struct {
      logic        valid;
      logic [31:0] data;
      logic        ack;
      logic [2:0]  exp_level;
      logic        exp_stb;
      logic        exp_ready;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int  w;
      bit  done;
      bit  acc, hs, prev_hs;
      logic [2:0] lvl_after_pop;

      // Fill with ack low: FIFO fills after four accepts, word 1 held on the output.
      vecs[0] = '{1'b1, 32'd1, 1'b0, 3'd1, 1'b0, 1'b1, 32'd0};
      vecs[1] = '{1'b1, 32'd2, 1'b0, 3'd2, 1'b1, 1'b1, 32'd1};
      vecs[2] = '{1'b1, 32'd3, 1'b0, 3'd3, 1'b1, 1'b1, 32'd1};
      vecs[3] = '{1'b1, 32'd4, 1'b0, 3'd4, 1'b1, 1'b0, 32'd1};
      vecs[4] = '{1'b1, 32'd5, 1'b0, 3'd4, 1'b1, 1'b0, 32'd1};
      vecs[5] = '{1'b1, 32'd5, 1'b0, 3'd4, 1'b1, 1'b0, 32'd1};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_stb", 32'(out_stb), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_words", words_sent, 0);
      chk("rst_ready", 32'(in_ready), 0);
      chk("rst_data", out_data, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("ready_after_rst", 32'(in_ready), 1);

      // Single word with ack held high
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1; out_ack = 1'b1;
      @(posedge clk); #1;
      chk("single_level_n", 32'(level), 1);
      chk("single_stb_n", 32'(out_stb), 0);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk); #1;
      chk("single_stb_n1", 32'(out_stb), 1);
      chk("single_data_n1", out_data, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      chk("single_stb_n2", 32'(out_stb), 0);
      chk("single_words", words_sent, 1);
      chk("single_level_end", 32'(level), 0);
      @(negedge clk);
      out_ack = 1'b0;

      // Table: back-to-back push with ack low
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = vecs[i].valid; in_data = vecs[i].data; in_last = 1'b0;
         out_ack = vecs[i].ack;
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
         chk($sformatf("tbl%0d_stb", i), 32'(out_stb), 32'(vecs[i].exp_stb));
         chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
         if (vecs[i].exp_stb) chk($sformatf("tbl%0d_data", i), out_data, vecs[i].exp_data);
      end

      // Drain with ack held high while feeding words 5 and 6
      w = 5; done = 1'b0; prev_hs = 1'b0; lvl_after_pop = '0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         in_valid = (w <= 6); in_data = 32'(w); in_last = (w == 6); out_ack = 1'b1;
         #1;
         acc = in_valid && in_ready;
         hs  = out_stb;
         @(posedge clk); #1;
         if (acc) w++;
         if (prev_hs && lvl_after_pop != 0) chk("stb_after_gap", 32'(out_stb), 1);
         if (hs) begin
            chk("stb_low_after_ack", 32'(out_stb), 0);
            lvl_after_pop = level;
         end
         prev_hs = hs;
         if (words_sent == 32'd7 && level == 3'd0 && w == 7) done = 1'b1;
      end
      chk("drain_done", 32'(done), 1);
      chk("drain_words", words_sent, 7);
      chk("drain_level", 32'(level), 0);
      chk("drain_sb_empty", 32'(sb_q.size()), 0);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; out_ack = 1'b0;
      @(posedge clk); #1;

      // Ack in IDLE is ignored
      @(negedge clk);
      out_ack = 1'b1;
      @(posedge clk); #1;
      chk("idle_ack_stb", 32'(out_stb), 0);
      chk("idle_ack_words", words_sent, 7);
      @(negedge clk);
      out_ack = 1'b0;

      // Ack across the GAP cycle pops only one word
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'hA0A0_A0A0;
      @(posedge clk);
      @(negedge clk);
      in_data = 32'hB0B0_B0B0;
      @(posedge clk); #1;
      chk("gap_pre_stb", 32'(out_stb), 1);
      @(negedge clk);
      in_valid = 1'b0; out_ack = 1'b1;
      @(posedge clk); #1;
      chk("gap_stb_low", 32'(out_stb), 0);
      chk("gap_words_a", words_sent, 8);
      @(posedge clk); #1;
      chk("gap_stb_b", 32'(out_stb), 1);
      chk("gap_data_b", out_data, 32'hB0B0_B0B0);
      chk("gap_words_b", words_sent, 8);
      chk("gap_level_b", 32'(level), 1);
      @(posedge clk); #1;
      chk("gap_words_c", words_sent, 9);
      @(posedge clk); #1;
      chk("gap_idle_words", words_sent, 9);
      @(negedge clk);
      out_ack = 1'b0;

      // Reset mid-transfer with three words buffered
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 32'h11 * (i + 1);
         @(posedge clk);
      end
      #1;
      chk("mid_pre_stb", 32'(out_stb), 1);
      chk("mid_pre_level", 32'(level), 3);
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b0;
      sb_q.delete();
      #1;
      chk("mid_rst_stb", 32'(out_stb), 0);
      chk("mid_rst_level", 32'(level), 0);
      chk("mid_rst_words", words_sent, 0);
      chk("mid_rst_ready", 32'(in_ready), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h55; in_last = 1'b1; out_ack = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      wait_ws("post_rst_words", 32'd1, 10);
      @(posedge clk); #1;
      chk("post_rst_level", 32'(level), 0);
      chk("post_rst_sb_empty", 32'(sb_q.size()), 0);
      @(negedge clk);
      out_ack = 1'b0;

      // Counter wrap from a forced all-ones value
      @(negedge clk);
      force dut.words_sent_q = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.words_sent_q;
      #1;
      chk("wrap_preload", words_sent, 32'hFFFF_FFFF);
      in_valid = 1'b1; in_data = 32'h77; out_ack = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_ws("wrap_to_zero", 32'd0, 10);
      chk("wrap_level", 32'(level), 0);
      @(negedge clk);
      out_ack = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
